// File: rtl/key_debounce_array.sv
// Multi-channel keypad front end: 2-FF synchroniser, symmetric counter debounce, per-key
// hold/long/repeat FSM and a registered lowest-index key encoder.
module key_debounce_array #(
    parameter int unsigned NUM_KEYS   = 4,
    parameter int unsigned CODE_W     = 2,
    parameter int unsigned CNT_W      = 18,
    parameter int unsigned CNT_END    = 249999,
    parameter int unsigned HOLD_W     = 26,
    parameter int unsigned LONG_CYC   = 50000000,
    parameter int unsigned REPEAT_CYC = 10000000,
    parameter int unsigned REPEAT_EN  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [NUM_KEYS-1:0] key_repeat,
    output logic                key_valid,
    output logic [CODE_W-1:0]   key_code
);

    typedef enum logic [1:0] {StIdle, StHold, StRepeat} hold_state_e;

    logic [NUM_KEYS-1:0]             sync1_q, sync2_q, raw;
    logic [NUM_KEYS-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_KEYS-1:0]             level_q, level_d, accept;
    logic [NUM_KEYS-1:0]             press_q, press_d, release_q, release_d;
    logic [NUM_KEYS-1:0]             long_q, long_d, repeat_q, repeat_d;
    logic [NUM_KEYS-1:0]             long_done_q, long_done_d;
    logic [NUM_KEYS-1:0][HOLD_W-1:0] hcnt_q, hcnt_d;
    hold_state_e                     state_q [NUM_KEYS];
    hold_state_e                     state_d [NUM_KEYS];
    logic [NUM_KEYS-1:0]             ev;
    logic                            valid_q, valid_d;
    logic [CODE_W-1:0]               code_q, code_d;

    assign raw = ~sync2_q;

    always_comb begin
        accept    = '0;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
            accept[i] = (raw[i] != level_q[i]) && (cnt_q[i] == CNT_W'(CNT_END));
            if (raw[i] == level_q[i] || accept[i]) begin
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
            if (accept[i]) begin
                level_d[i] = raw[i];
            end
            press_d[i]   = accept[i] & raw[i];
            release_d[i] = accept[i] & ~raw[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        hcnt_d      = hcnt_q;
        long_done_d = long_done_q;
        long_d      = '0;
        repeat_d    = '0;
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
            // A release wins over any long/repeat that would fire on the same edge.
            if (release_d[i]) begin
                state_d[i]     = StIdle;
                hcnt_d[i]      = '0;
                long_done_d[i] = 1'b0;
            end else begin
                unique case (state_q[i])
                    StIdle: begin
                        if (press_d[i]) begin
                            state_d[i]     = StHold;
                            hcnt_d[i]      = '0;
                            long_done_d[i] = 1'b0;
                        end
                    end
                    StHold: begin
                        if (!long_done_q[i]) begin
                            if (hcnt_q[i] == HOLD_W'(LONG_CYC - 1)) begin
                                long_d[i] = 1'b1;
                                if (REPEAT_EN != 0) begin
                                    state_d[i] = StRepeat;
                                    hcnt_d[i]  = '0;
                                end else begin
                                    long_done_d[i] = 1'b1;
                                end
                            end else begin
                                hcnt_d[i] = hcnt_q[i] + 1'b1;
                            end
                        end
                    end
                    StRepeat: begin
                        if (hcnt_q[i] == HOLD_W'(REPEAT_CYC - 1)) begin
                            repeat_d[i] = 1'b1;
                            hcnt_d[i]   = '0;
                        end else begin
                            hcnt_d[i] = hcnt_q[i] + 1'b1;
                        end
                    end
                    default: state_d[i] = StIdle;
                endcase
            end
        end
    end

    assign ev = press_q | repeat_q;

    always_comb begin
        valid_d = |ev;
        code_d  = code_q;
        for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
            if (ev[i]) begin
                code_d = CODE_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            cnt_q       <= '0;
            level_q     <= '0;
            press_q     <= '0;
            release_q   <= '0;
            long_q      <= '0;
            repeat_q    <= '0;
            long_done_q <= '0;
            hcnt_q      <= '0;
            valid_q     <= 1'b0;
            code_q      <= '0;
            for (int i = 0; i < int'(NUM_KEYS); i++) begin
                state_q[i] <= StIdle;
            end
        end else begin
            sync1_q     <= key;
            sync2_q     <= sync1_q;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
            long_done_q <= long_done_d;
            hcnt_q      <= hcnt_d;
            valid_q     <= valid_d;
            code_q      <= code_d;
            for (int i = 0; i < int'(NUM_KEYS); i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;
    assign key_repeat  = repeat_q;
    assign key_valid   = valid_q;
    assign key_code    = code_q;

endmodule

// File: tb/tb_key_debounce_array.sv
// Bench for key_debounce_array: a run-length/elapsed-time model checked every cycle against
// two instances (repeat enabled and disabled), plus directed literal checkpoints.
module tb_key_debounce_array;

    localparam int CE = 9;
    localparam int LC = 40;
    localparam int RC = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] key = 4'hf;

    logic [3:0] key_level, key_press, key_release, key_long, key_repeat;
    logic       key_valid;
    logic [1:0] key_code;
    logic [3:0] nr_level, nr_press, nr_release, nr_long, nr_repeat;
    logic       nr_valid;
    logic [1:0] nr_code;

    key_debounce_array #(
        .NUM_KEYS(4), .CODE_W(2), .CNT_W(4), .CNT_END(CE), .HOLD_W(6),
        .LONG_CYC(LC), .REPEAT_CYC(RC), .REPEAT_EN(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key(key),
        .key_level(key_level), .key_press(key_press), .key_release(key_release),
        .key_long(key_long), .key_repeat(key_repeat),
        .key_valid(key_valid), .key_code(key_code)
    );

    key_debounce_array #(
        .NUM_KEYS(4), .CODE_W(2), .CNT_W(4), .CNT_END(CE), .HOLD_W(6),
        .LONG_CYC(LC), .REPEAT_CYC(RC), .REPEAT_EN(0)
    ) dut_nr (
        .clk(clk), .rst_n(rst_n), .key(key),
        .key_level(nr_level), .key_press(nr_press), .key_release(nr_release),
        .key_long(nr_long), .key_repeat(nr_repeat),
        .key_valid(nr_valid), .key_code(nr_code)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Model: delayed sample stream, run lengths and edges elapsed since the press.
    logic [3:0] m_s1, m_s2, m_prev, m_lvl, m_press, m_rel, m_long, m_rep;
    logic       m_valid, m_valid_nr;
    logic [1:0] m_code, m_code_nr;
    int         m_run  [4];
    int         m_held [4];

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_s1 = 4'hf; m_s2 = 4'hf; m_prev = '0; m_lvl = '0;
            m_press = '0; m_rel = '0; m_long = '0; m_rep = '0;
            m_valid = 1'b0; m_valid_nr = 1'b0; m_code = '0; m_code_nr = '0;
            for (int i = 0; i < 4; i++) begin
                m_run[i]  = 0;
                m_held[i] = -1;
            end
        end else begin
            m_valid    = |(m_press | m_rep);
            m_valid_nr = |m_press;
            for (int i = 3; i >= 0; i--) begin
                if (m_press[i] || m_rep[i]) m_code = 2'(i);
                if (m_press[i]) m_code_nr = 2'(i);
            end
            for (int i = 0; i < 4; i++) begin
                logic r, acc;
                r = ~m_s2[i];
                m_run[i] = (r == m_prev[i]) ? m_run[i] + 1 : 1;
                m_prev[i] = r;
                acc = (r != m_lvl[i]) && (m_run[i] == CE + 1);
                m_press[i] = acc && r;
                m_rel[i]   = acc && !r;
                if (acc) m_lvl[i] = r;
                m_long[i] = 1'b0;
                m_rep[i]  = 1'b0;
                if (m_rel[i]) begin
                    m_held[i] = -1;
                end else if (m_held[i] >= 0) begin
                    m_held[i]++;
                    if (m_held[i] == LC) m_long[i] = 1'b1;
                    if (m_held[i] > LC && (m_held[i] - LC) % RC == 0) m_rep[i] = 1'b1;
                end
                if (m_press[i]) m_held[i] = 0;
            end
            m_s2 = m_s1;
            m_s1 = key;
        end
    end

    int press1_dut = 0;
    int press1_mdl = 0;

    initial forever begin
        @(negedge clk);
        if (cyc >= 1) begin
            check("level",       32'(key_level),   32'(m_lvl));
            check("press",       32'(key_press),   32'(m_press));
            check("release",     32'(key_release), 32'(m_rel));
            check("long",        32'(key_long),    32'(m_long));
            check("repeat",      32'(key_repeat),  32'(m_rep));
            check("valid",       32'(key_valid),   32'(m_valid));
            check("code",        32'(key_code),    32'(m_code));
            check("nr_level",    32'(nr_level),    32'(m_lvl));
            check("nr_press",    32'(nr_press),    32'(m_press));
            check("nr_release",  32'(nr_release),  32'(m_rel));
            check("nr_long",     32'(nr_long),     32'(m_long));
            check("nr_repeat",   32'(nr_repeat),   32'(0));
            check("nr_valid",    32'(nr_valid),    32'(m_valid_nr));
            check("nr_code",     32'(nr_code),     32'(m_code_nr));
        end
        if (key_press[1]) press1_dut++;
        if (m_press[1]) press1_mdl++;
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] mdl,
                       input logic [31:0] want);
        check({name, " dut"}, act, want);
        check({name, " model"}, mdl, want);
    endtask

    // Returns 1 ns after edge n.
    task automatic at_edge(input int n);
        forever begin
            if (cyc >= n) break;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int p;
        int lens [7] = '{3, 9, 5, 7, 4, 8, 6};
        int offs [2] = '{39, 40};
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Clean press/release on key 0
        t0 = cyc; key[0] = 1'b0;
        at_edge(t0 + 11); lit("t1 press early", 32'(key_press), 32'(m_press), 0);
        at_edge(t0 + 12); lit("t1 press", 32'(key_press), 32'(m_press), 1);
        lit("t1 level", 32'(key_level), 32'(m_lvl), 1);
        at_edge(t0 + 13); lit("t1 press width", 32'(key_press), 32'(m_press), 0);
        lit("t1 valid", 32'(key_valid), 32'(m_valid), 1);
        lit("t1 code", 32'(key_code), 32'(m_code), 0);
        at_edge(t0 + 30); @(negedge clk); key[0] = 1'b1;
        at_edge(t0 + 41); lit("t1 release early", 32'(key_release), 32'(m_rel), 0);
        at_edge(t0 + 42); lit("t1 release", 32'(key_release), 32'(m_rel), 1);
        lit("t1 level off", 32'(key_level), 32'(m_lvl), 0);
        at_edge(t0 + 43); lit("t1 release width", 32'(key_release), 32'(m_rel), 0);

        // Bouncing key 1, runs of 3..9 cycles, ending released
        @(negedge clk);
        t0 = 0; p = 0;
        while (t0 < 200) begin
            key[1] = p[0];
            repeat (lens[p % 7]) @(negedge clk);
            t0 += lens[p % 7];
            p++;
        end
        key[1] = 1'b1;
        repeat (20) @(negedge clk);
        lit("t2 level", 32'(key_level[1]), 32'(m_lvl[1]), 0);
        lit("t2 presses", 32'(press1_dut), 32'(press1_mdl), 0);

        // Long hold on key 2
        t0 = cyc; key[2] = 1'b0;
        at_edge(t0 + 12); lit("t3 press", 32'(key_press), 32'(m_press), 4);
        at_edge(t0 + 13); lit("t3 valid", 32'(key_valid), 32'(m_valid), 1);
        lit("t3 code", 32'(key_code), 32'(m_code), 2);
        lit("t3 nr code", 32'(nr_code), 32'(m_code_nr), 2);
        at_edge(t0 + 51); lit("t3 long early", 32'(key_long), 32'(m_long), 0);
        at_edge(t0 + 52); lit("t3 long", 32'(key_long), 32'(m_long), 4);
        check("t3 nr long", 32'(nr_long), 32'(4));
        at_edge(t0 + 53); lit("t3 long valid", 32'(key_valid), 32'(m_valid), 0);
        at_edge(t0 + 67); lit("t3 repeat1", 32'(key_repeat), 32'(m_rep), 4);
        check("t3 nr repeat", 32'(nr_repeat), 32'(0));
        at_edge(t0 + 68); lit("t3 rep valid", 32'(key_valid), 32'(m_valid), 1);
        lit("t3 rep code", 32'(key_code), 32'(m_code), 2);
        lit("t3 nr valid", 32'(nr_valid), 32'(m_valid_nr), 0);
        at_edge(t0 + 82); lit("t3 repeat2", 32'(key_repeat), 32'(m_rep), 4);
        at_edge(t0 + 100); @(negedge clk); key[2] = 1'b1;
        at_edge(t0 + 112); lit("t3 release", 32'(key_release), 32'(m_rel), 4);
        lit("t3 no rep on release", 32'(key_repeat), 32'(m_rep), 0);
        at_edge(t0 + 116);

        // Simultaneous presses on keys 1 and 3
        @(negedge clk);
        t0 = cyc; key[3] = 1'b0; key[1] = 1'b0;
        at_edge(t0 + 12); lit("t4 press", 32'(key_press), 32'(m_press), 4'b1010);
        at_edge(t0 + 13); lit("t4 valid", 32'(key_valid), 32'(m_valid), 1);
        lit("t4 code", 32'(key_code), 32'(m_code), 1);
        at_edge(t0 + 14); lit("t4 valid once", 32'(key_valid), 32'(m_valid), 0);
        lit("t4 code hold", 32'(key_code), 32'(m_code), 1);
        at_edge(t0 + 20); @(negedge clk); key[3] = 1'b1; key[1] = 1'b1;
        at_edge(t0 + 36);

        // Reset while key 0 is held
        @(negedge clk);
        t0 = cyc; key[0] = 1'b0;
        at_edge(t0 + 12); lit("t5 press", 32'(key_press), 32'(m_press), 1);
        at_edge(t0 + 30); @(negedge clk); rst_n = 1'b0;
        at_edge(t0 + 32); lit("t5 rst level", 32'(key_level), 32'(m_lvl), 0);
        lit("t5 rst code", 32'(key_code), 32'(m_code), 0);
        at_edge(t0 + 35); @(negedge clk); rst_n = 1'b1;
        at_edge(t0 + 46); lit("t5 repress early", 32'(key_press), 32'(m_press), 0);
        at_edge(t0 + 47); lit("t5 repress", 32'(key_press), 32'(m_press), 1);
        at_edge(t0 + 50); @(negedge clk); key[0] = 1'b1;
        at_edge(t0 + 66);

        // Release just before / on the long-press edge
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            t0 = cyc; key[0] = 1'b0;
            p = t0 + 12;
            at_edge(p + offs[k] - 12); @(negedge clk); key[0] = 1'b1;
            at_edge(p + offs[k]); lit("t6 release", 32'(key_release), 32'(m_rel), 1);
            lit("t6 no long", 32'(key_long), 32'(m_long), 0);
            at_edge(p + 40); lit("t6 no long at 40", 32'(key_long), 32'(m_long), 0);
            at_edge(p + 41); lit("t6 no long at 41", 32'(key_long), 32'(m_long), 0);
            at_edge(p + 46);
        end

        // Fresh hold after an aborted one still times a full LONG_CYC
        @(negedge clk);
        t0 = cyc; key[0] = 1'b0;
        at_edge(t0 + 51); lit("t7 long early", 32'(key_long), 32'(m_long), 0);
        at_edge(t0 + 52); lit("t7 long", 32'(key_long), 32'(m_long), 1);
        check("t7 nr long", 32'(nr_long), 32'(1));
        at_edge(t0 + 55); @(negedge clk); key[0] = 1'b1;
        at_edge(t0 + 72);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
